// File: rtl/dac_atten_pkg.sv
// rtl/dac_atten_pkg.sv - shared types for the attenuation DAC sequencer
package dac_atten_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        SELECT,
        STROBE,
        HOLD
    } state_e;

    typedef struct packed {
        logic       side;
        logic       sel_a;
        logic [7:0] value;
    } atten_cmd_t;

    localparam logic SIDE_LEFT  = 1'b0;
    localparam logic SIDE_RIGHT = 1'b1;

endpackage

// File: rtl/dac_cmd_fifo.sv
// rtl/dac_cmd_fifo.sv - synchronous command FIFO with full/empty flags
module dac_cmd_fifo
    import dac_atten_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  atten_cmd_t push_data,
    input  logic       pop,
    output atten_cmd_t pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    atten_cmd_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/dac_atten_sequencer.sv
// rtl/dac_atten_sequencer.sv - serialises queued attenuation factors into the 74HC164/AD7528 pair
module dac_atten_sequencer
    import dac_atten_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_side,
    input  logic       cmd_sel_a,
    input  logic [7:0] cmd_value,
    output logic       datadac,
    output logic       clkdac,
    output logic       csdac1n,
    output logic       csdac2n,
    output logic       busy,
    output logic [7:0] shadow_la,
    output logic [7:0] shadow_lb,
    output logic [7:0] shadow_ra,
    output logic [7:0] shadow_rb
);

    localparam int              TW         = $clog2(CLK_DIV + 1);
    localparam logic [TW-1:0]   PHASE_LAST = TW'(CLK_DIV - 1);

    state_e         state;
    state_e         state_next;
    logic [TW-1:0]  phase;
    logic           phase_done;
    logic [2:0]     bit_idx;
    atten_cmd_t     cmd_reg;
    atten_cmd_t     in_cmd;
    atten_cmd_t     head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop;

    assign in_cmd     = {cmd_side, cmd_sel_a, cmd_value};
    assign cmd_ready  = !fifo_full;
    assign busy       = (state != IDLE) || !fifo_empty;
    assign phase_done = (phase == PHASE_LAST);

    dac_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (cmd_valid),
        .push_data(in_cmd),
        .pop      (pop),
        .pop_data (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = SHIFT_LO;
                end
            end
            SHIFT_LO: if (phase_done) state_next = SHIFT_HI;
            SHIFT_HI: if (phase_done) state_next = (bit_idx == 3'd0) ? SELECT : SHIFT_LO;
            SELECT:   if (phase_done) state_next = STROBE;
            STROBE:   if (phase_done) state_next = HOLD;
            HOLD:     if (phase_done) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            phase   <= '0;
            bit_idx <= 3'd7;
            cmd_reg <= '0;
        end else begin
            state <= state_next;
            phase <= (state == IDLE || phase_done) ? '0 : phase + 1'b1;
            if (pop) begin
                cmd_reg <= head;
                bit_idx <= 3'd7;
            end else if (state == SHIFT_HI && phase_done && bit_idx != 3'd0) begin
                bit_idx <= bit_idx - 3'd1;
            end
        end
    end

    // Pins follow the state one cycle late, so every phase is a clean registered window.
    always_ff @(posedge clk) begin
        if (reset) begin
            datadac <= 1'b0;
            clkdac  <= 1'b0;
            csdac1n <= 1'b1;
            csdac2n <= 1'b1;
        end else begin
            clkdac  <= 1'b0;
            csdac1n <= 1'b1;
            csdac2n <= 1'b1;
            case (state)
                SHIFT_LO: datadac <= cmd_reg.value[bit_idx];
                SHIFT_HI: clkdac  <= 1'b1;
                SELECT:   datadac <= cmd_reg.sel_a;
                STROBE: begin
                    csdac1n <= (cmd_reg.side != SIDE_LEFT);
                    csdac2n <= (cmd_reg.side != SIDE_RIGHT);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_la <= 8'h00;
            shadow_lb <= 8'h00;
            shadow_ra <= 8'h00;
            shadow_rb <= 8'h00;
        end else if (state == HOLD && phase_done) begin
            if (cmd_reg.side == SIDE_LEFT) begin
                if (cmd_reg.sel_a) shadow_la <= cmd_reg.value;
                else               shadow_lb <= cmd_reg.value;
            end else begin
                if (cmd_reg.sel_a) shadow_ra <= cmd_reg.value;
                else               shadow_rb <= cmd_reg.value;
            end
        end
    end

endmodule
